// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: run controller for sim/FPGA harnesses. Holds the DUT in reset
// for RST_HOLD edges and then counts run cycles. It stops the run on a
// channel exit, a max-cycle watchdog or a hang.
// Ports: clk, rst (sync, active-high), cfg_max_cycle, cfg_hang_limit,
//   activity, ch_exit_valid, ch_exit_code -> dut_rst, running, cycle_cnt,
//   done, fail, cause, status_code, done_ch.
module sim_run_ctrl #(
  parameter int CNT_W    = 64,
  parameter int HANG_W   = 32,
  parameter int N_CH     = 2,
  parameter int CODE_W   = 8,
  parameter int RST_HOLD = 13,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CNT_W-1:0]       cfg_max_cycle,
  input  logic [HANG_W-1:0]      cfg_hang_limit,
  input  logic                   activity,
  input  logic [N_CH-1:0]        ch_exit_valid,
  input  logic [N_CH*CODE_W-1:0] ch_exit_code,
  output logic                   dut_rst,
  output logic                   running,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic                   done,
  output logic                   fail,
  output logic [1:0]             cause,
  output logic [CODE_W-1:0]      status_code,
  output logic [CH_W-1:0]        done_ch
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD + 1) : 1;

  localparam logic [1:0] C_EXIT = 2'd1;
  localparam logic [1:0] C_MAX  = 2'd2;
  localparam logic [1:0] C_HANG = 2'd3;

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_DONE
  } state_t;

  state_t              state, state_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_n;
  logic [CNT_W-1:0]    cyc_n, cyc_inc;
  logic [HANG_W-1:0]   idle_cnt, idle_n, idle_inc;
  logic                done_n, fail_n;
  logic [1:0]          cause_n;
  logic [CODE_W-1:0]   code_n;
  logic [CH_W-1:0]     ch_n;

  logic                ex_hit;
  logic [CH_W-1:0]     ex_idx;
  logic [CODE_W-1:0]   ex_code;
  logic                max_hit, hang_hit;

  // Lowest-index channel wins: scan high to low so the last hit is lowest.
  always_comb begin
    ex_hit  = |ch_exit_valid;
    ex_idx  = '0;
    ex_code = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_exit_valid[i]) begin
        ex_idx  = CH_W'(i);
        ex_code = ch_exit_code[i*CODE_W +: CODE_W];
      end
    end
  end

  // Saturating next-count values; the limit compares use these.
  assign cyc_inc  = (&cycle_cnt) ? cycle_cnt
                  : cycle_cnt + CNT_W'(1);
  assign idle_inc = (&idle_cnt) ? idle_cnt
                  : idle_cnt + HANG_W'(1);

  assign max_hit  = (|cfg_max_cycle)
                 && (cyc_inc == cfg_max_cycle);
  assign hang_hit = (|cfg_hang_limit) && !activity
                 && (idle_inc == cfg_hang_limit);

  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    cyc_n   = cycle_cnt;
    idle_n  = idle_cnt;
    done_n  = done;
    fail_n  = fail;
    cause_n = cause;
    code_n  = status_code;
    ch_n    = done_ch;
    unique case (state)
      S_HOLD: begin
        hold_n = hold_cnt - HOLD_W'(1);
        if (hold_cnt == HOLD_W'(1)) state_n = S_RUN;
      end
      S_RUN: begin
        cyc_n  = cyc_inc;
        idle_n = activity ? '0 : idle_inc;
        if (ex_hit) begin
          state_n = S_DONE;
          done_n  = 1'b1;
          cause_n = C_EXIT;
          ch_n    = ex_idx;
          code_n  = ex_code;
          fail_n  = |ex_code;
        end else if (max_hit) begin
          state_n = S_DONE;
          done_n  = 1'b1;
          cause_n = C_MAX;
          code_n  = '1;
          fail_n  = 1'b1;
        end else if (hang_hit) begin
          state_n = S_DONE;
          done_n  = 1'b1;
          cause_n = C_HANG;
          code_n  = '1;
          fail_n  = 1'b1;
        end
      end
      S_DONE: ;
      default: state_n = S_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_HOLD;
      hold_cnt    <= HOLD_W'(RST_HOLD);
      cycle_cnt   <= '0;
      idle_cnt    <= '0;
      done        <= 1'b0;
      fail        <= 1'b0;
      cause       <= 2'd0;
      status_code <= '0;
      done_ch     <= '0;
    end else begin
      state       <= state_n;
      hold_cnt    <= hold_n;
      cycle_cnt   <= cyc_n;
      idle_cnt    <= idle_n;
      done        <= done_n;
      fail        <= fail_n;
      cause       <= cause_n;
      status_code <= code_n;
      done_ch     <= ch_n;
    end
  end

  assign dut_rst = (state == S_HOLD);
  assign running = (state == S_RUN);

endmodule
